// File: rtl/alu_cmd_initiator.sv
// Command initiator for the ALU en/A/B/OP -> result/done interface.
// Turns a valid/ready command stream into one en pulse per op and returns results on a valid/ready response stream.
module alu_cmd_initiator #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 2,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic              en,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   OP,
  input  logic [RES_W-1:0]  result,
  input  logic              done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic [CNT_W-1:0]  spur_cnt
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
  logic                cmd_ready_d, en_d, rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0]   a_d, b_d;
  logic [OP_W-1:0]     op_d;
  logic [RES_W-1:0]    rsp_result_d;
  logic [CNT_W-1:0]    txn_cnt_d, spur_cnt_d;
  logic                spur_hit;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d      = state_q;
    wait_cnt_d   = wait_cnt;
    cmd_ready_d  = 1'b0;
    en_d         = 1'b0;
    a_d          = A;
    b_d          = B;
    op_d         = OP;
    rsp_valid_d  = rsp_valid;
    rsp_result_d = rsp_result;
    rsp_err_d    = rsp_err;
    txn_cnt_d    = txn_cnt;
    spur_hit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        spur_hit    = done;
        cmd_ready_d = 1'b1;
        // cmd_ready is registered, so it gates the handshake as seen upstream
        if (cmd_valid && cmd_ready) begin
          a_d         = cmd_a;
          b_d         = cmd_b;
          op_d        = cmd_op;
          en_d        = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        spur_hit   = done;
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // done takes priority over a timeout landing on the same edge
        if (done) begin
          rsp_result_d = result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        spur_hit = done;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_cnt_d   = txn_cnt + 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    spur_cnt_d = (spur_hit && (spur_cnt != '1)) ? spur_cnt + 1'b1 : spur_cnt;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt   <= '0;
      cmd_ready  <= 1'b0;
      en         <= 1'b0;
      A          <= '0;
      B          <= '0;
      OP         <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      txn_cnt    <= '0;
      spur_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q    <= state_d;
      wait_cnt   <= wait_cnt_d;
      cmd_ready  <= cmd_ready_d;
      en         <= en_d;
      A          <= a_d;
      B          <= b_d;
      OP         <= op_d;
      rsp_valid  <= rsp_valid_d;
      rsp_result <= rsp_result_d;
      rsp_err    <= rsp_err_d;
      txn_cnt    <= txn_cnt_d;
      spur_cnt   <= spur_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Scoreboard bench for alu_cmd_initiator: directed commands push expected responses,
// a negedge monitor pops and compares each response as it appears.
module tb_alu_cmd_initiator;

  localparam int DATA_W  = 8;
  localparam int OP_W    = 2;
  localparam int RES_W   = 16;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic              CLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic [OP_W-1:0]   cmd_op = '0;
  logic              en;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [OP_W-1:0]   OP;
  logic [RES_W-1:0]  result = '0;
  logic              done = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_err;
  logic [CNT_W-1:0]  txn_cnt;
  logic [CNT_W-1:0]  spur_cnt;

  always #5 CLK = ~CLK;

  alu_cmd_initiator #(
    .DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .en(en), .A(A), .B(B), .OP(OP),
    .result(result), .done(done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .txn_cnt(txn_cnt), .spur_cnt(spur_cnt)
  );

  typedef struct {
    logic [RES_W-1:0] res;
    logic             err;
    int               lat;      // -1 = latency not checked
    int               acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, why);
  endtask

  // ALU model: result = A+B, done for one cycle alu_delay cycles after the en cycle (0 = never)
  int                alu_delay = 2;
  int                cd = 0;
  int                en_count = 0;
  logic [RES_W-1:0]  pend = '0;
  logic [DATA_W-1:0] last_a = '0;
  logic [DATA_W-1:0] last_b = '0;
  logic [OP_W-1:0]   last_op = '0;

  always @(negedge CLK) begin
    done = 1'b0;
    if (!rst_n) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          done   = 1'b1;
          result = pend;
        end
      end
      if (en) begin
        en_count++;
        last_a  = A;
        last_b  = B;
        last_op = OP;
        pend    = RES_W'(A) + RES_W'(B);
        cd      = alu_delay;
      end
    end
  end

  // Response monitor
  logic             prev_valid = 1'b0;
  logic [RES_W-1:0] cur_res = '0;
  logic             cur_err = 1'b0;
  exp_t             mon_e;

  always @(negedge CLK) begin
    if (rsp_valid) begin
      if (!prev_valid) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_rsp", "response with empty scoreboard");
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          if (mon_e.lat >= 0) check("rsp_latency", cyc - mon_e.acc_cyc, mon_e.lat);
        end
        cur_res = rsp_result;
        cur_err = rsp_err;
      end else begin
        check("rsp_result_stable", 32'(rsp_result), 32'(cur_res));
        check("rsp_err_stable", 32'(rsp_err), 32'(cur_err));
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [OP_W-1:0] op, input logic [RES_W-1:0] exp_res,
                      input logic exp_err, input int exp_lat);
    exp_t e;
    int   n;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      fail_now("cmd_accept", "cmd_ready never asserted");
      cmd_valid = 1'b0;
    end else begin
      e.res     = exp_res;
      e.err     = exp_err;
      e.lat     = exp_lat;
      e.acc_cyc = cyc;
      sb_q.push_back(e);
      @(negedge CLK);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      #1;
      if (sb_q.size() == 0 && !rsp_valid) break;
    end
    if (!(sb_q.size() == 0 && !rsp_valid)) fail_now(name, "response never completed");
  endtask

  int base_en;

  initial begin
    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_en", 32'(en), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_A", 32'(A), 0);
    check("rst_B", 32'(B), 0);
    check("rst_OP", 32'(OP), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_result", 32'(rsp_result), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_txn_cnt", 32'(txn_cnt), 0);
    check("rst_spur_cnt", 32'(spur_cnt), 0);
    rst_n = 1'b1;
    @(negedge CLK);
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Single op
    base_en = en_count;
    send(8'h12, 8'h34, 2'd0, 16'h0046, 1'b0, 4);
    wait_idle("single_op");
    check("single_en_pulses", en_count - base_en, 1);
    check("single_A", 32'(last_a), 32'h12);
    check("single_B", 32'(last_b), 32'h34);
    check("single_OP", 32'(last_op), 0);
    check("single_txn_cnt", 32'(txn_cnt), 1);

    // Backpressure
    rsp_ready = 1'b0;
    base_en = en_count;
    send(8'hA0, 8'h0F, 2'd1, 16'h00AF, 1'b0, 4);
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      #1;
      if (rsp_valid) break;
    end
    if (!rsp_valid) fail_now("bp_rsp_valid", "rsp_valid never asserted");
    repeat (5) begin
      @(negedge CLK);
      #1;
      check("bp_cmd_ready", 32'(cmd_ready), 0);
      check("bp_rsp_valid_held", 32'(rsp_valid), 1);
    end
    check("bp_en_pulses", en_count - base_en, 1);
    rsp_ready = 1'b1;
    @(negedge CLK);
    #1;
    check("bp_rsp_valid_drop", 32'(rsp_valid), 0);
    check("bp_txn_cnt", 32'(txn_cnt), 2);

    // Timeout, then a late done counted as spurious
    alu_delay = 20;
    send(8'h55, 8'h11, 2'd2, 16'h0000, 1'b1, 18);
    wait_idle("timeout");
    repeat (8) @(negedge CLK);
    #1;
    check("timeout_txn_cnt", 32'(txn_cnt), 3);
    check("late_done_spur_cnt", 32'(spur_cnt), 1);

    // done on the last WAIT cycle
    alu_delay = 16;
    send(8'h7F, 8'h80, 2'd3, 16'h00FF, 1'b0, 18);
    wait_idle("collision");
    check("collision_txn_cnt", 32'(txn_cnt), 4);
    check("collision_spur_cnt", 32'(spur_cnt), 1);

    // Reset during WAIT
    alu_delay = 0;
    send(8'h01, 8'h02, 2'd0, 16'h0003, 1'b0, -1);
    repeat (4) @(negedge CLK);
    rst_n = 1'b0;
    #1;
    check("midrst_en", 32'(en), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_txn_cnt", 32'(txn_cnt), 0);
    check("midrst_spur_cnt", 32'(spur_cnt), 0);
    check("midrst_A", 32'(A), 0);
    @(negedge CLK);
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge CLK);
    #1;
    check("midrst_cmd_ready", 32'(cmd_ready), 1);
    alu_delay = 2;
    send(8'h20, 8'h22, 2'd1, 16'h0042, 1'b0, 4);
    wait_idle("post_reset_op");
    check("post_reset_txn_cnt", 32'(txn_cnt), 1);

    // Back-to-back with rsp_ready held high
    base_en = en_count;
    for (int i = 1; i <= 10; i++)
      send(DATA_W'(i), DATA_W'(2 * i), OP_W'(i), RES_W'(3 * i), 1'b0, 4);
    wait_idle("back_to_back");
    check("b2b_en_pulses", en_count - base_en, 10);
    check("b2b_txn_cnt", 32'(txn_cnt), 11);
    check("b2b_spur_cnt", 32'(spur_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
